// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters, same-cycle
// lookup for fetch, resolution-port training, mispredict detection and stats.

module btb_entry #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_target,
  input  logic [1:0]       wr_ctr,
  input  logic             wr_jmp,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [XLEN-1:0]  target,
  output logic [1:0]       ctr,
  output logic             jmp
);

  // Flush only drops valid; payload fields are left as-is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= '0;
      jmp    <= 1'b0;
    end else if (flush) begin
      valid  <= 1'b0;
    end else if (wr_en) begin
      valid  <= 1'b1;
      tag    <= wr_tag;
      target <= wr_target;
      ctr    <= wr_ctr;
      jmp    <= wr_jmp;
    end
  end

endmodule

module btb_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_branch,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             flush_all,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] ctl_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [ENTRIES-1:0]                 valid_q, jmp_q;
  logic [ENTRIES-1:0][TAG_W-1:0]      tag_q;
  logic [ENTRIES-1:0][XLEN-1:0]       target_q;
  logic [ENTRIES-1:0][1:0]            ctr_q;

  logic [IDX-1:0]   lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic             lk_hit, u_hit, upd_ctl;
  logic             wr_any, wr_jmp;
  logic [1:0]       wr_ctr;
  logic [XLEN-1:0]  wr_target;

  assign lk_idx = lookup_pc[IDX+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX+2];
  assign u_idx  = upd_pc[IDX+1:2];
  assign u_tag  = upd_pc[XLEN-1:IDX+2];

  assign lk_hit      = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit & (jmp_q[lk_idx] | ctr_q[lk_idx][1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);

  assign upd_ctl = upd_valid & (upd_is_branch | upd_is_jump);
  assign u_hit   = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

  // Jump wins when both type flags are set; a miss that was not taken leaves the table alone.
  always_comb begin
    wr_any    = 1'b0;
    wr_ctr    = ctr_q[u_idx];
    wr_jmp    = jmp_q[u_idx];
    wr_target = target_q[u_idx];
    if (upd_ctl && !flush_all) begin
      if (u_hit) begin
        wr_any = 1'b1;
        if (upd_is_jump) begin
          wr_ctr    = 2'b11;
          wr_jmp    = 1'b1;
          wr_target = upd_target;
        end else if (upd_taken) begin
          wr_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          wr_target = upd_target;
        end else begin
          wr_ctr    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        wr_any    = 1'b1;
        wr_jmp    = upd_is_jump;
        wr_ctr    = upd_is_jump ? 2'b11 : 2'b10;
        wr_target = upd_target;
      end
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    btb_entry #(.XLEN(XLEN), .TAG_W(TAG_W)) u_entry (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_all),
      .wr_en     (wr_any && (u_idx == IDX'(g))),
      .wr_tag    (u_tag),
      .wr_target (wr_target),
      .wr_ctr    (wr_ctr),
      .wr_jmp    (wr_jmp),
      .valid     (valid_q[g]),
      .tag       (tag_q[g]),
      .target    (target_q[g]),
      .ctr       (ctr_q[g]),
      .jmp       (jmp_q[g])
    );
  end

  // A non-control instruction predicted taken is itself a mispredict; fall through.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = upd_pc + XLEN'(4);
    if (upd_valid) begin
      if (upd_ctl) begin
        mispredict = (upd_pred_taken != upd_taken) |
                     (upd_taken & (upd_pred_target != upd_target));
        if (upd_taken) redirect_pc = upd_target;
      end else begin
        mispredict = upd_pred_taken;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd_ctl && (ctl_cnt != '1))     ctl_cnt  <= ctl_cnt + CNT_W'(1);
      if (mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: stimulus queues expected outputs, a
// negedge monitor pops and compares them against the combinational outputs.

module tb_btb_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
  logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken, flush_all;

  logic        pred_taken, mispredict;
  logic [31:0] pred_target, redirect_pc, ctl_cnt, miss_cnt;

  logic        pt4, mp4;
  logic [31:0] ptg4, rd4;
  logic [3:0]  ctl4, miss4;

  btb_predictor dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_all(flush_all), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .ctl_cnt(ctl_cnt), .miss_cnt(miss_cnt)
  );

  btb_predictor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_taken(pt4), .pred_target(ptg4),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_all(flush_all), .mispredict(mp4), .redirect_pc(rd4),
    .ctl_cnt(ctl4), .miss_cnt(miss4)
  );

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_ctl = 0;
  int   exp_miss = 0;

  task automatic push(input string n, input int s, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic push_cnt(input string n);
    push({n, ".ctl_cnt"}, 4, exp_ctl);
    push({n, ".miss_cnt"}, 5, exp_miss);
    push({n, ".miss_cnt4"}, 6, (exp_miss > 15) ? 32'd15 : exp_miss);
  endtask

  function automatic logic [31:0] observe(input int s);
    case (s)
      0:       observe = {31'b0, pred_taken};
      1:       observe = pred_target;
      2:       observe = {31'b0, mispredict};
      3:       observe = redirect_pc;
      4:       observe = ctl_cnt;
      5:       observe = miss_cnt;
      6:       observe = {28'b0, miss4};
      default: observe = 'x;
    endcase
  endfunction

  exp_t        mon_e;
  logic [31:0] mon_a;
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_a = observe(mon_e.sig);
      checks++;
      if (mon_a !== mon_e.val) begin
        errors++;
        $display("FAIL %s: actual %h required %h at %0t", mon_e.name, mon_a, mon_e.val, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] tg, input string n);
    step();
    upd_valid = 1'b0; upd_is_branch = 1'b0; upd_is_jump = 1'b0; flush_all = 1'b0;
    lookup_pc = pc;
    push({n, ".pred_taken"}, 0, {31'b0, tk});
    push({n, ".pred_target"}, 1, tg);
    push({n, ".mispredict"}, 2, 32'd0);
    push_cnt(n);
  endtask

  task automatic upd(input string n, input logic [31:0] pc, input logic br, input logic jp,
                     input logic tk, input logic [31:0] tg, input logic ptk,
                     input logic [31:0] ptg, input logic fl, input logic emp,
                     input logic [31:0] erd);
    step();
    upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jp;
    upd_taken = tk; upd_target = tg; upd_pred_taken = ptk; upd_pred_target = ptg;
    flush_all = fl; lookup_pc = pc;
    push({n, ".mispredict"}, 2, {31'b0, emp});
    push({n, ".redirect_pc"}, 3, erd);
    push_cnt(n);
    if (br || jp) exp_ctl++;
    if (emp) exp_miss++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; lookup_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
    upd_is_branch = 1'b0; upd_is_jump = 1'b0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0; flush_all = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    look(32'h100, 1'b0, 32'h104, "reset");

    // learn, then walk the counter through its hysteresis
    upd("learn", 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 0, 1, 32'h80);
    push("learn.nobypass", 0, 32'd0);
    look(32'h100, 1'b1, 32'h80, "learned");
    upd("nt1", 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 0, 1, 32'h104);
    look(32'h100, 1'b0, 32'h104, "ctr01");
    upd("nt2", 32'h100, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h104);
    look(32'h100, 1'b0, 32'h104, "ctr00");
    upd("t1", 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 0, 1, 32'h80);
    look(32'h100, 1'b0, 32'h104, "ctr01b");
    upd("t2", 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 0, 1, 32'h80);
    upd("t3", 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 0, 0, 32'h80);
    look(32'h100, 1'b1, 32'h80, "ctr11");
    upd("nt3", 32'h100, 1, 0, 0, 32'h0, 1, 32'h80, 0, 1, 32'h104);
    look(32'h100, 1'b1, 32'h80, "ctr10");

    // alias on index 0
    look(32'h140, 1'b0, 32'h144, "alias_miss");
    upd("alias_upd", 32'h140, 1, 0, 1, 32'h300, 0, 32'h0, 0, 1, 32'h300);
    look(32'h100, 1'b0, 32'h104, "alias_evicted");
    look(32'h140, 1'b1, 32'h300, "alias_new");
    upd("miss_nt", 32'h100, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h104);
    look(32'h140, 1'b1, 32'h300, "miss_nt_nowrite");

    // jumps stay taken regardless of counter
    upd("jal", 32'h20, 0, 1, 1, 32'h400, 0, 32'h0, 0, 1, 32'h400);
    look(32'h20, 1'b1, 32'h400, "jal_look");
    upd("jal_nt1", 32'h20, 1, 0, 0, 32'h0, 1, 32'h400, 0, 1, 32'h24);
    upd("jal_nt2", 32'h20, 1, 0, 0, 32'h0, 1, 32'h400, 0, 1, 32'h24);
    look(32'h20, 1'b1, 32'h400, "jmp_sticky");
    upd("wrong_tgt", 32'h20, 0, 1, 1, 32'h500, 1, 32'h400, 0, 1, 32'h500);
    look(32'h20, 1'b1, 32'h500, "new_tgt");
    upd("nt_ok", 32'h30, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h34);
    look(32'h30, 1'b0, 32'h34, "nt_ok_look");
    upd("nonctl_pt", 32'h50, 0, 0, 1, 32'h999, 1, 32'h0, 0, 1, 32'h54);
    upd("nonctl_pn", 32'h50, 0, 0, 1, 32'h999, 0, 32'h0, 0, 0, 32'h54);
    upd("jal_right", 32'h20, 0, 1, 1, 32'h500, 1, 32'h500, 0, 0, 32'h500);

    // flush beats same-cycle update, stats still count
    upd("flush", 32'h100, 1, 0, 1, 32'h80, 0, 32'h0, 1, 1, 32'h80);
    look(32'h100, 1'b0, 32'h104, "flush_100");
    look(32'h140, 1'b0, 32'h144, "flush_140");
    look(32'h20, 1'b0, 32'h24, "flush_20");

    for (int i = 0; i < 20; i++)
      upd("sat", 32'h1000, 0, 0, 1, 32'h0, 1, 32'h0, 0, 1, 32'h1004);
    look(32'h1000, 1'b0, 32'h1004, "sat_hold");

    // reset mid-operation with a live update
    upd("relearn", 32'h20, 0, 1, 1, 32'h400, 0, 32'h0, 0, 1, 32'h400);
    look(32'h20, 1'b1, 32'h400, "relearn_look");
    step();
    rst = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h24; upd_is_branch = 1'b0; upd_is_jump = 1'b1;
    upd_taken = 1'b1; upd_target = 32'h700; upd_pred_taken = 1'b0; lookup_pc = 32'h20;
    exp_ctl = 0; exp_miss = 0;
    push("rst_async.pred_taken", 0, 32'd0);
    push_cnt("rst_async");
    step();
    rst = 1'b1; upd_valid = 1'b0; upd_is_jump = 1'b0;
    push("rst_release.pred_taken", 0, 32'd0);
    push_cnt("rst_release");
    look(32'h24, 1'b0, 32'h28, "rst_nocommit");

    step();
    step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with 2-bit saturating direction counters, feeding next-PC selection in IF and trained from branch resolution in EX/MEM. It removes the fixed predict-not-taken penalty of the 5-stage pipeline: a hit on a learned taken branch or jump redirects fetch in the same cycle. The same resolution port reports mispredictions and the recovery PC to hazard control. Hardware statistics counters support performance measurement.

## Interface

- `ENTRIES`, default 16. Number of direct-mapped entries; must be a power of 2 and at least 2. `IDX = log2(ENTRIES)`.
- `XLEN`, default 32. PC and target width. Tag is `pc[XLEN-1:IDX+2]`; index is `pc[IDX+1:2]`.
- `CNT_W`, default 32. Width of each statistics counter.

- `clk` in 1: clock; every register updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `lookup_pc` in XLEN: current fetch PC.
- `pred_taken` out 1: the lookup hit and predicts taken.
- `pred_target` out XLEN: predicted next PC.
- `upd_valid` in 1: a resolved instruction is presented this cycle.
- `upd_pc` in XLEN: PC of the resolved instruction.
- `upd_is_branch` in 1: the instruction is a conditional branch.
- `upd_is_jump` in 1: the instruction is JAL or JALR.
- `upd_taken` in 1: actual direction.
- `upd_target` in XLEN: actual target.
- `upd_pred_taken` in 1: the prediction made for this instruction at fetch, carried down the pipeline.
- `upd_pred_target` in XLEN: the predicted target, carried down the pipeline.
- `flush_all` in 1: invalidate all entries (fence.i, context switch).
- `mispredict` out 1: the resolved instruction was mispredicted.
- `redirect_pc` out XLEN: correct next PC to use on a mispredict.
- `ctl_cnt` out CNT_W: count of resolved branches and jumps.
- `miss_cnt` out CNT_W: count of mispredictions.

## Operation

- **Entry contents:** `valid`, `tag`, `target[XLEN]`, `ctr[1:0]`, `jmp`.
- **Lookup (combinational):**
  - `hit = valid[idx] & (tag[idx] == lookup_pc tag)`.
  - `pred_taken = hit & (jmp[idx] | ctr[idx][1])`.
  - `pred_target = pred_taken ? target[idx] : lookup_pc + 4`. Addition is modulo 2^XLEN.
- **Update:** active when `upd_valid & (upd_is_branch | upd_is_jump)`. Indexing uses `upd_pc`.
  - **Hit:**
    - Branch taken: `ctr` saturating-increments toward 11 and `target <= upd_target`.
    - Branch not taken: `ctr` saturating-decrements toward 00; `target` is unchanged.
    - Jump: `ctr <= 11`, `jmp <= 1`, `target <= upd_target`.
  - **Miss and taken:** allocate the entry, replacing any existing occupant.
    - `valid <= 1`, tag from `upd_pc`, `target <= upd_target`.
    - `ctr <= 10` for a branch, `11` for a jump.
    - `jmp <= upd_is_jump`.
  - **Miss and not taken:** no table write.
  - If both `upd_is_branch` and `upd_is_jump` are asserted, the instruction is treated as a jump.
- **Misprediction (combinational):**
  - `mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_target != upd_target))`.
  - `redirect_pc = upd_taken ? upd_target : upd_pc + 4`.
  - If `upd_valid` is asserted with neither `upd_is_branch` nor `upd_is_jump`: `mispredict = upd_pred_taken`, and `redirect_pc = upd_pc + 4`.
- **Statistics:**
  - `ctl_cnt` increments on every qualifying update.
  - `miss_cnt` increments on every cycle with `mispredict` high.
  - Both saturate at all-ones and never wrap.
- **flush_all:**
  - Clears every `valid` bit at the next edge.
  - Takes priority over a same-cycle update: that table write is dropped.
  - Statistics still count that update.
  - `ctr`, `tag`, `target` are not cleared.

## Timing

- **Reset values:**
  - All `valid` = 0; `ctl_cnt` = 0; `miss_cnt` = 0.
  - Hence `pred_taken` = 0 and `pred_target` = `lookup_pc + 4`.
  - `mispredict` = 0 while `upd_valid` = 0.
- **Latency:**
  - Lookup and mispredict detection: 0 cycles, purely combinational.
  - A table write is visible to lookup 1 cycle after the update edge.
- **Same entry looked up and updated in one cycle:** lookup returns the pre-update contents (no bypass).
- **Reset mid-operation:** asserting `rst` clears state immediately, independent of `clk`. No update is committed on an edge while `rst` is low.
- **Hazard control:** `mispredict` must be consumed by hazard control in the same cycle it is asserted, to flush the younger stages and select `redirect_pc`.

## Test plan

Default parameters unless stated.

- **Reset:**
  - Stimulus: `rst` low, then high; `lookup_pc = 0x100`.
  - Required: `pred_taken` = 0, `pred_target` = 0x104, `ctl_cnt` = 0, `miss_cnt` = 0.
- **Learn a taken branch:**
  - Stimulus: update `pc = 0x100`, branch, taken, `target = 0x80`, `upd_pred_taken = 0`.
  - Required that cycle: `mispredict` = 1, `redirect_pc` = 0x80.
  - Required next cycle: lookup of 0x100 gives `pred_taken` = 1 and `pred_target` = 0x80; `ctl_cnt` = 1, `miss_cnt` = 1.
- **Hysteresis:**
  - Stimulus: continuing from the previous scenario, apply not-taken updates at 0x100.
  - After one not-taken update: `ctr` = 01 and lookup is not taken, with `pred_target` = 0x104.
  - After a second: `ctr` = 00.
  - Then one taken update: `ctr` = 01, lookup is still not taken.
  - Then two further taken updates: `ctr` = 11, lookup is taken to 0x80.
- **Alias:**
  - Setup: entry for 0x100 valid.
  - Lookup of 0x140 (same index, different tag) -> miss, `pred_target` = 0x144.
  - Taken update at 0x140 to 0x300 -> lookup of 0x100 now misses, and lookup of 0x140 predicts 0x300.
- **Jump and wrong-target:**
  - JAL update at 0x20 to 0x400 -> entry is always taken thereafter.
  - Update with `upd_pred_taken` = 1, `upd_pred_target` = 0x400, `upd_target` = 0x500 -> `mispredict` = 1, `redirect_pc` = 0x500.
  - Predicted not taken and actually not taken at 0x30 -> `mispredict` = 0.
- **Flush and saturation:**
  - `flush_all` in the same cycle as a taken update at 0x100 -> all lookups miss next cycle, and `ctl_cnt` still increments.
  - With `CNT_W` = 4: 20 mispredicts -> `miss_cnt` holds at 0xF.
